led_pattern_engine: RTL and testbench

Parametrised LED pattern generator for the board's red LED bank, driven from the board clock. It provides four selectable animation modes (bounce, rotate-left, rotate-right, bar fill/empty), a programmable step rate, a pause control and a per-step strobe. Its output drives the LED pins directly. A compile-time option adds a global PWM brightness control.

---
 rtl/led_pattern_pkg.sv | 14 +
 rtl/led_tick_gen.sv | 40 ++++
 rtl/led_pattern_engine.sv | 142 ++++++++++++++
 tb/tb_led_pattern_engine.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern engine: mode encoding and PWM width.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_ROTL   = 2'd1,
    MODE_ROTR   = 2'd2,
    MODE_BAR    = 2'd3
  } mode_e;

  localparam int PWM_W = 4;
  localparam int SPD_W = 3;

endpackage

// File: rtl/led_tick_gen.sv
// Base-tick prescaler and step divider; emits a one-cycle step request.
module led_tick_gen
  import led_pattern_pkg::*;
#(
  parameter int TICK_DIV = 2097152
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iCLEAR,
  input  logic             iPAUSE,
  input  logic [SPD_W-1:0] iSPEED,
  output logic             oSTEP
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] PRE_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0]    r_pre;
  logic [SPD_W-1:0] r_div;
  logic             w_tick;

  assign w_tick = (r_pre == PRE_MAX) && !iPAUSE;
  assign oSTEP  = w_tick && (r_div == iSPEED);

  // Prescaler and divider; a divider left above a lowered speed clears without stepping.
  always_ff @(posedge iCLK) begin
    if (iRST || iCLEAR) begin
      r_pre <= '0;
      r_div <= '0;
    end else begin
      if (!iPAUSE) begin
        r_pre <= (r_pre == PRE_MAX) ? '0 : r_pre + 1'b1;
      end
      if (w_tick) begin
        r_div <= (r_div >= iSPEED) ? '0 : r_div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern generator: bounce, rotate-left, rotate-right and bar modes with
// programmable step rate and pause. Optional PWM brightness gating is enabled
// by defining LED_PATTERN_PWM_EN, which adds the iBRIGHT port.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int SEG      = 3,
  parameter int TICK_DIV = 2097152
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [1:0]       iMODE,
  input  logic [SPD_W-1:0] iSPEED,
  input  logic             iPAUSE,
`ifdef LED_PATTERN_PWM_EN
  input  logic [PWM_W-1:0] iBRIGHT,
`endif
  output logic [WIDTH-1:0] oLED,
  output logic             oSTEP,
  output logic             oDIR
);

  localparam int PW = $clog2(WIDTH + 1);
  localparam logic [PW-1:0] W_P      = PW'(WIDTH);
  localparam logic [PW-1:0] BNC_MAX  = PW'(WIDTH - SEG);
  localparam logic [PW-1:0] BAR_MAX  = PW'(WIDTH);
  localparam logic [PW-1:0] ROT_MAX  = PW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SEG_PAT = {{(WIDTH - SEG){1'b0}}, {SEG{1'b1}}};

  mode_e            r_mode;
  mode_e            w_mode_nxt;
  mode_e            w_mode_in;
  logic [PW-1:0]    r_pos;
  logic [PW-1:0]    w_pos_nxt;
  logic [PW-1:0]    w_limit;
  logic             r_dir;
  logic             w_dir_nxt;
  logic             r_step;
  logic             w_step_nxt;
  logic             w_step;
  logic             w_mode_chg;
  logic [WIDTH-1:0] w_pat;
  logic [WIDTH-1:0] w_led_d;
  logic [WIDTH-1:0] r_led;

  assign w_mode_in  = mode_e'(iMODE);
  assign w_mode_chg = (w_mode_in != r_mode);

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iCLEAR (w_mode_chg),
    .iPAUSE (iPAUSE),
    .iSPEED (iSPEED),
    .oSTEP  (w_step)
  );

  // Next pattern state; a mode change takes priority over a coincident step.
  always_comb begin
    w_mode_nxt = r_mode;
    w_pos_nxt  = r_pos;
    w_dir_nxt  = r_dir;
    w_step_nxt = 1'b0;
    w_limit    = (r_mode == MODE_BAR) ? BAR_MAX : BNC_MAX;
    if (w_mode_chg) begin
      w_mode_nxt = w_mode_in;
      w_pos_nxt  = '0;
      w_dir_nxt  = (w_mode_in == MODE_ROTR);
    end else if (w_step) begin
      w_step_nxt = 1'b1;
      unique case (r_mode)
        MODE_ROTL, MODE_ROTR: begin
          w_pos_nxt = (r_pos == ROT_MAX) ? '0 : r_pos + 1'b1;
          w_dir_nxt = (r_mode == MODE_ROTR);
        end
        default: begin
          // Direction flips on the step that lands on an end, so each end shows once.
          if (!r_dir) begin
            w_pos_nxt = r_pos + 1'b1;
            if (r_pos == w_limit - 1'b1) w_dir_nxt = 1'b1;
          end else begin
            w_pos_nxt = r_pos - 1'b1;
            if (r_pos == PW'(1)) w_dir_nxt = 1'b0;
          end
        end
      endcase
    end
  end

  // Pattern decode from the next state, so oLED lands with the step.
  always_comb begin
    w_pat = '0;
    unique case (w_mode_nxt)
      MODE_BOUNCE: w_pat = SEG_PAT << w_pos_nxt;
      MODE_ROTL:   w_pat = (SEG_PAT << w_pos_nxt) | (SEG_PAT >> (W_P - w_pos_nxt));
      MODE_ROTR:   w_pat = (SEG_PAT >> w_pos_nxt) | (SEG_PAT << (W_P - w_pos_nxt));
      MODE_BAR:    w_pat = ~({WIDTH{1'b1}} << w_pos_nxt);
      default:     w_pat = '0;
    endcase
  end

`ifdef LED_PATTERN_PWM_EN
  logic [PWM_W-1:0] r_pwm;
  logic             w_pwm_en;

  assign w_pwm_en = (r_pwm < iBRIGHT) || (iBRIGHT == '1);
  assign w_led_d  = w_pat & {WIDTH{w_pwm_en}};

  // Free-running PWM phase counter.
  always_ff @(posedge iCLK) begin
    if (iRST) r_pwm <= '0;
    else      r_pwm <= r_pwm + 1'b1;
  end
`else
  assign w_led_d = w_pat;
`endif

  // State and output registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_mode <= MODE_BOUNCE;
      r_pos  <= '0;
      r_dir  <= 1'b0;
      r_step <= 1'b0;
      r_led  <= SEG_PAT;
    end else begin
      r_mode <= w_mode_nxt;
      r_pos  <= w_pos_nxt;
      r_dir  <= w_dir_nxt;
      r_step <= w_step_nxt;
      r_led  <= w_led_d;
    end
  end

  assign oLED  = r_led;
  assign oSTEP = r_step;
  assign oDIR  = r_dir;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine (WIDTH=10, SEG=3, TICK_DIV=4).
module tb_led_pattern_engine;

  localparam int W  = 10;
  localparam int S  = 3;
  localparam int TD = 4;
  localparam int L  = W - S;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   mode = 2'd0;
  logic [2:0]   speed = 3'd0;
  logic         pause = 1'b0;
  logic [3:0]   bright = 4'd15;
  logic [W-1:0] led;
  logic         stp;
  logic         dir;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: position in the unrolled animation cycle plus timing counts.
  int m_mode, m_idx, m_pre, m_ticks, m_pwm;
  int unsigned m_led;
  int unsigned m_step, m_dir;

  always #5 clk = ~clk;

  led_pattern_engine #(
    .WIDTH    (W),
    .SEG      (S),
    .TICK_DIV (TD)
  ) dut (
    .iCLK    (clk),
    .iRST    (rst),
    .iMODE   (mode),
    .iSPEED  (speed),
    .iPAUSE  (pause),
`ifdef LED_PATTERN_PWM_EN
    .iBRIGHT (bright),
`endif
    .oLED    (led),
    .oSTEP   (stp),
    .oDIR    (dir)
  );

  function automatic int seq_len(input int md);
    case (md)
      0:       return 2 * L;
      3:       return 2 * W;
      default: return W;
    endcase
  endfunction

  function automatic int unsigned exp_pat(input int md, input int k);
    int unsigned seg, mask;
    int p;
    seg  = (1 << S) - 1;
    mask = (1 << W) - 1;
    case (md)
      0: begin p = (k <= L) ? k : 2 * L - k; return (seg << p) & mask; end
      1: return ((seg << k) | (seg >> (W - k))) & mask;
      2: return ((seg >> k) | (seg << (W - k))) & mask;
      default: begin p = (k <= W) ? k : 2 * W - k; return ((1 << p) - 1) & mask; end
    endcase
  endfunction

  function automatic int unsigned exp_dir(input int md, input int k);
    case (md)
      0:       return (k >= L) ? 1 : 0;
      1:       return 0;
      2:       return 1;
      default: return (k >= W) ? 1 : 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    int en;
    if (rst) begin
      m_mode = 0; m_idx = 0; m_pre = 0; m_ticks = 0; m_pwm = 0;
      m_step = 0; m_dir = 0; m_led = exp_pat(0, 0);
      return;
    end
    m_step = 0;
    if (int'(mode) != m_mode) begin
      m_mode = int'(mode); m_idx = 0; m_pre = 0; m_ticks = 0;
    end else if (!pause) begin
      if (m_pre == TD - 1) begin
        m_pre = 0;
        if (m_ticks == int'(speed)) begin
          m_step = 1; m_ticks = 0; m_idx = (m_idx + 1) % seq_len(m_mode);
        end else if (m_ticks > int'(speed)) begin
          m_ticks = 0;
        end else begin
          m_ticks++;
        end
      end else begin
        m_pre++;
      end
    end
    m_dir = exp_dir(m_mode, m_idx);
    m_led = exp_pat(m_mode, m_idx);
`ifdef LED_PATTERN_PWM_EN
    en = (m_pwm < int'(bright)) || (bright == 4'd15);
    if (en == 0) m_led = 0;
`else
    en = 1;
`endif
    m_pwm = (m_pwm + en - en + 1) % 16;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    check("led", 32'(led), m_led);
    check("step", 32'(stp), m_step);
    check("dir", 32'(dir), m_dir);
  endtask

  task automatic run_steps(input int n);
    int got;
    got = 0;
    for (int i = 0; i < n * 64 && got < n; i++) begin
      cyc();
      if (m_step != 0) got++;
    end
    check("steps_reached", got, n);
  endtask

  task automatic gap_to_step(input int pause_at, input int pause_len, input int exp_gap);
    int cnt;
    bit seen;
    cnt  = 0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (cnt == pause_at && pause_len > 0) pause = 1'b1;
      if (cnt == pause_at + pause_len) pause = 1'b0;
      cyc();
      cnt++;
      if (stp) seen = 1;
    end
    pause = 1'b0;
    check("step_gap", cnt, exp_gap);
  endtask

  initial begin
    int lit;
    bit found;

    // Reset
    rst = 1'b1;
    cyc();
    cyc();
    check("rst_led", 32'(led), 32'h007);
    check("rst_dir", 32'(dir), 0);
    check("rst_step", 32'(stp), 0);
    rst = 1'b0;

    // Bounce up to the top end, then back down
    run_steps(7);
    check("bnc_top", 32'(led), 32'h380);
    check("bnc_top_dir", 32'(dir), 1);
    run_steps(1);
    check("bnc_down", 32'(led), 32'h1C0);
    run_steps(6);
    check("bnc_home", 32'(led), 32'h007);
    check("bnc_home_dir", 32'(dir), 0);
    gap_to_step(99, 0, 4);

    // Rotate left with wrap
    mode = 2'd1;
    cyc();
    check("rotl_start", 32'(led), 32'h007);
    run_steps(7);
    check("rotl_380", 32'(led), 32'h380);
    run_steps(1);
    check("rotl_wrap", 32'(led), 32'h301);

    // Rotate right with wrap
    mode = 2'd2;
    cyc();
    check("rotr_start", 32'(led), 32'h007);
    run_steps(1);
    check("rotr_wrap", 32'(led), 32'h203);
    run_steps(12);

    // Bar fill/empty
    mode = 2'd3;
    cyc();
    check("bar_start", 32'(led), 32'h000);
    run_steps(10);
    check("bar_full", 32'(led), 32'h3FF);
    run_steps(1);
    check("bar_after_full", 32'(led), 32'h1FF);
    run_steps(9);
    check("bar_empty", 32'(led), 32'h000);
    run_steps(1);
    check("bar_after_empty", 32'(led), 32'h001);

    // Slow speed and pause stretch
    mode  = 2'd0;
    speed = 3'd2;
    cyc();
    gap_to_step(99, 0, 12);
    gap_to_step(99, 0, 12);
    gap_to_step(2, 20, 32);

    // Mode change on the same cycle as a step
    speed = 3'd0;
    found = 0;
    for (int i = 0; i < 32 && !found; i++) begin
      if (m_pre == TD - 1 && m_ticks == int'(speed)) found = 1;
      else cyc();
    end
    check("align_found", 32'(found), 1);
    mode = 2'd3;
    cyc();
    check("chg_no_step", 32'(stp), 0);
    check("chg_start", 32'(led), 32'h000);

    // Reset in the middle of a bounce
    mode = 2'd0;
    cyc();
    run_steps(5);
    check("mid_bnc", 32'(led), 32'h0E0);
    rst   = 1'b1;
    pause = 1'b1;
    cyc();
    check("mid_rst_led", 32'(led), 32'h007);
    check("mid_rst_dir", 32'(dir), 0);
    check("mid_rst_step", 32'(stp), 0);
    rst   = 1'b0;
    pause = 1'b0;

    // Randomised mode, speed, pause and reset activity against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) speed = 3'($urandom_range(0, 7));
      pause = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst   = 1'b0;
    pause = 1'b0;

`ifdef LED_PATTERN_PWM_EN
    // Brightness 4: a frozen pattern is visible 4 of every 16 cycles
    mode   = 2'd0;
    bright = 4'd4;
    cyc();
    pause = 1'b1;
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (led != '0) lit++;
    end
    check("pwm_duty", lit, 4);
    bright = 4'd0;
    cyc();
    cyc();
    check("pwm_off", 32'(led), 0);
    pause  = 1'b0;
    bright = 4'd15;
`else
    lit = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
